// File: rtl/d_mem_streamer.sv
// Sequential read engine in front of the combinational data memory: fetches a block of
// consecutive words, streams them over valid/ready and keeps a modular checksum.
module d_mem_streamer #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   count,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [AW:0]   REM_ONE  = (AW+1)'(1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   rem_q, rem_d;
   logic [DW-1:0] data_q, data_d;
   logic          vld_q, vld_d;
   logic          done_q, done_d;
   logic [DW-1:0] csum_q, csum_d;
   logic          capture;

   function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] acc, input logic [DW-1:0] word);
      return acc + word;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      vld_d   = vld_q;
      done_d  = 1'b0;
      csum_d  = csum_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = base;
               rem_d   = count;
               csum_d  = '0;
               state_d = (count == '0) ? DONE : READ;
               done_d  = (count == '0);
            end
         end
         READ: begin
            capture = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (rem_q != '0) begin
                  capture = 1'b1;
               end else begin
                  vld_d   = 1'b0;
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A capture takes the word at the current address and steps to the next one.
      if (capture) begin
         data_d = mem_data;
         vld_d  = 1'b1;
         csum_d = csum_add(csum_q, mem_data);
         addr_d = addr_q + ADDR_ONE;
         rem_d  = rem_q - REM_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         csum_q  <= csum_d;
      end
   end

   assign mem_addr  = addr_q;
   assign out_data  = data_q;
   assign out_valid = vld_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign checksum  = csum_q;

endmodule

// File: tb/tb_d_mem_streamer.sv
// Bench for d_mem_streamer: directed table of transfers, reset abort sequence and
// randomized transfers checked against a word-list/checksum model of the memory.
module tb_d_mem_streamer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] base;
   logic [8:0] count;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic [7:0] checksum;

   logic [7:0] mem [256];
   int checks = 0;
   int fails  = 0;

   assign mem_data = mem[mem_addr];

   always #5 clk = ~clk;

   d_mem_streamer #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
      .mem_addr(mem_addr), .mem_data(mem_data), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .done(done), .checksum(checksum)
   );

   typedef struct {
      logic [7:0]      base;
      logic [8:0]      count;
      logic [3:0][7:0] w;
      int              stall;
      bit              restart;
      logic [7:0]      exp_csum;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One complete transfer: stall>=0 holds ready low that many cycles per word, stall<0 is random.
   task automatic run_xfer(input logic [7:0] b, input logic [8:0] c, input int stall,
                           input bit restart, input bit use_exp, input logic [7:0] exp_cs);
      logic [7:0] model [$];
      logic [7:0] sum;
      logic [7:0] prev_data;
      int  k, hold, cyc;
      bit  exp_done, finished, prev_held;
      model.delete();
      sum = 8'h00;
      for (int i = 0; i < int'(c); i++) begin
         model.push_back(mem[(int'(b) + i) % 256]);
         sum = sum + mem[(int'(b) + i) % 256];
      end
      start = 1'b1; base = b; count = c; out_ready = 1'b0;
      @(posedge clk); #1;
      if (restart) begin
         base = 8'h99; count = 9'd1;
      end else begin
         start = 1'b0;
      end
      k = 0; hold = 0; cyc = 0; prev_data = 8'h00;
      exp_done = (c == 9'd0); finished = 1'b0; prev_held = 1'b0;
      while (!finished) begin
         if (stall < 0) out_ready = 1'($urandom_range(0, 1));
         else if (out_valid && hold < stall) begin
            out_ready = 1'b0; hold++;
         end else out_ready = 1'b1;
         @(negedge clk);
         chk("done_timing", 32'(done), 32'(exp_done));
         if (prev_held && out_valid) chk("hold_stable", 32'(out_data), 32'(prev_data));
         if (out_valid) begin
            if (k < int'(c)) chk("word", 32'(out_data), 32'(model[k]));
            else chk("extra_word", 32'(out_valid), 32'd0);
            chk("mem_addr", 32'(mem_addr), 32'((int'(b) + k + 1) % 256));
         end
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            k++; hold = 0; prev_held = 1'b0;
            if (k == int'(c)) exp_done = 1'b1;
         end else begin
            prev_held = out_valid; prev_data = out_data;
         end
         if (done) finished = 1'b1;
         cyc++;
         if (cyc >= 6000 && !finished) begin
            chk("timeout_done", 32'(done), 32'd1);
            finished = 1'b1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("words_taken", 32'(k), 32'(c));
      chk("csum_model", 32'(checksum), 32'(sum));
      if (use_exp) chk("csum_table", 32'(checksum), 32'(exp_cs));
      chk("addr_idle", 32'(mem_addr), 32'((int'(b) + int'(c)) % 256));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      vt[0] = '{8'h00, 9'd2, {8'h00, 8'h00, 8'h02, 8'h01}, 0, 1'b0, 8'h03};
      vt[1] = '{8'h10, 9'd0, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 8'h00};
      vt[2] = '{8'h05, 9'd3, {8'h00, 8'hA2, 8'hA1, 8'hA0}, 3, 1'b0, 8'hE3};
      vt[3] = '{8'hFF, 9'd3, {8'h00, 8'h02, 8'h01, 8'h10}, 0, 1'b0, 8'h13};
      vt[4] = '{8'h20, 9'd4, {8'h80, 8'h80, 8'h80, 8'h80}, 1, 1'b1, 8'h00};

      rst = 1'b1; start = 1'b1; base = 8'h33; count = 9'd5; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_csum", 32'(checksum), 32'd0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 5; v++) begin
         for (int j = 0; j < 4; j++) mem[(int'(vt[v].base) + j) % 256] = vt[v].w[j];
         run_xfer(vt[v].base, vt[v].count, vt[v].stall, vt[v].restart, 1'b1, vt[v].exp_csum);
      end

      // Abort with the second word pending.
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) mem[8'h40 + j] = 8'(8'h50 + j);
      start = 1'b1; base = 8'h40; count = 9'd4; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("abort_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("abort_word1", 32'(out_data), 32'h51);
      #2 rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", 32'(out_data), 32'd0);
      chk("abort_mem_addr", 32'(mem_addr), 32'd0);
      chk("abort_csum", 32'(checksum), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_done", 32'(done), 32'd0);
      run_xfer(8'h60, 9'd2, 0, 1'b0, 1'b0, 8'h00);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         run_xfer(8'($urandom), 9'($urandom_range(0, (r % 3 == 0) ? 511 : 40)), -1, 1'b0, 1'b0, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
